// File: rtl/branch_address_queue.sv
// branch_address_queue: FIFO of pending branch destination addresses.
// The oldest entry is presented on Q. All state updates are gated by
// step = ClockEnable & Tick. There is a synchronous preset to one all-ones
// entry, and cs forces Q to zero.
// Optional feature macro: BRANCH_QUEUE_BYPASS_EN. When it is defined, an
// empty queue that sees a push forwards D straight onto Q in the same cycle.
module branch_address_queue #(
  parameter int NrOfBits = 32,
  parameter int Depth    = 4,
  parameter int CntBits  = $clog2(Depth) + 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                ClockEnable,
  input  logic                Tick,
  input  logic [NrOfBits-1:0] D,
  input  logic                Push,
  input  logic                Pop,
  input  logic                Flush,
  input  logic                pre,
  input  logic                cs,
  output logic [NrOfBits-1:0] Q,
  output logic                Empty,
  output logic                Full,
  output logic [CntBits-1:0]  Count,
  output logic                Overflow,
  output logic                Underflow
);

  localparam int AW = $clog2(Depth);

  logic [NrOfBits-1:0] r_mem [Depth];
  logic [AW-1:0]       r_rd, r_wr;
  logic [CntBits-1:0]  r_cnt;
  logic                r_ovf, r_udf;

  logic [AW-1:0]       w_rd_nxt, w_wr_nxt;
  logic [CntBits-1:0]  w_cnt_nxt;
  logic                w_ovf_nxt, w_udf_nxt;
  logic                w_step, w_empty, w_full;
  logic                w_pop_ok, w_push_ok, w_wen;
  logic                w_byp, w_byp_pop;

  assign w_step  = ClockEnable & Tick;
  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CntBits'(Depth));

  // The bypass is active only when a push actually reaches an empty queue
  // this cycle. A bypassed push that is popped at the same time never
  // touches storage.
`ifdef BRANCH_QUEUE_BYPASS_EN
  assign w_byp     = w_empty & Push & w_step & ~Flush & ~pre;
  assign w_byp_pop = w_byp & Pop;
`else
  assign w_byp     = 1'b0;
  assign w_byp_pop = 1'b0;
`endif

  assign w_pop_ok  = Pop & ~w_empty;
  assign w_push_ok = Push & (~w_full | w_pop_ok);

  // Next-state: Flush > pre > push/pop. Everything holds while step is low.
  always_comb begin
    w_rd_nxt  = r_rd;
    w_wr_nxt  = r_wr;
    w_cnt_nxt = r_cnt;
    w_ovf_nxt = r_ovf;
    w_udf_nxt = r_udf;
    w_wen     = 1'b0;
    if (w_step) begin
      if (Flush) begin
        w_rd_nxt  = '0;
        w_wr_nxt  = '0;
        w_cnt_nxt = '0;
        w_ovf_nxt = 1'b0;
        w_udf_nxt = 1'b0;
      end else if (pre) begin
        w_rd_nxt  = '0;
        w_wr_nxt  = AW'(1);
        w_cnt_nxt = CntBits'(1);
      end else if (!w_byp_pop) begin
        if (Pop && w_empty)     w_udf_nxt = 1'b1;
        if (Push && !w_push_ok) w_ovf_nxt = 1'b1;
        if (w_pop_ok)  w_rd_nxt = r_rd + 1'b1;
        if (w_push_ok) begin
          w_wr_nxt = r_wr + 1'b1;
          w_wen    = 1'b1;
        end
        if (w_push_ok && !w_pop_ok)      w_cnt_nxt = r_cnt + 1'b1;
        else if (w_pop_ok && !w_push_ok) w_cnt_nxt = r_cnt - 1'b1;
      end
    end
  end

  // Pointer, occupancy and sticky-flag registers. Reset clears them at once.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_rd  <= w_rd_nxt;
      r_wr  <= w_wr_nxt;
      r_cnt <= w_cnt_nxt;
      r_ovf <= w_ovf_nxt;
      r_udf <= w_udf_nxt;
    end
  end

  // Entry storage. It is not reset: contents are only meaningful below Count.
  always_ff @(posedge Clock) begin
    if (w_step && !Flush && pre) r_mem[0]    <= '1;
    else if (w_wen)              r_mem[r_wr] <= D;
  end

  assign Q         = cs ? '0 : (w_byp ? D : (w_empty ? '0 : r_mem[r_rd]));
  assign Empty     = w_empty;
  assign Full      = w_full;
  assign Count     = r_cnt;
  assign Overflow  = r_ovf;
  assign Underflow = r_udf;

endmodule

// File: tb/tb_branch_address_queue.sv
// Randomised and directed checks of branch_address_queue against a
// queue-based reference model of the FIFO rules.
module tb_branch_address_queue;

  localparam int NB = 32;
  localparam int DP = 4;
  localparam int CB = $clog2(DP) + 1;
`ifdef BRANCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          ClockEnable = 1'b0, Tick = 1'b0;
  logic [NB-1:0] D = '0;
  logic          Push = 1'b0, Pop = 1'b0, Flush = 1'b0, pre = 1'b0, cs = 1'b0;
  logic [NB-1:0] Q;
  logic          Empty, Full, Overflow, Underflow;
  logic [CB-1:0] Count;

  branch_address_queue #(.NrOfBits(NB), .Depth(DP)) dut (
    .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick),
    .D(D), .Push(Push), .Pop(Pop), .Flush(Flush), .pre(pre), .cs(cs),
    .Q(Q), .Empty(Empty), .Full(Full), .Count(Count),
    .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  logic [NB-1:0] mq[$];
  bit            m_ovf, m_udf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Checks every output against the model for the inputs currently applied.
  task automatic check_all(input string tag);
    bit st, byp;
    logic [NB-1:0] eq;
    st  = ClockEnable & Tick;
    byp = BYP && st && !Flush && !pre && Push && (mq.size() == 0);
    if (cs)                 eq = '0;
    else if (byp)           eq = D;
    else if (mq.size() == 0) eq = '0;
    else                    eq = mq[0];
    chk({tag, ".Q"},     64'(Q),         64'(eq));
    chk({tag, ".Count"}, 64'(Count),     64'(mq.size()));
    chk({tag, ".Empty"}, 64'(Empty),     64'(mq.size() == 0));
    chk({tag, ".Full"},  64'(Full),      64'(mq.size() == DP));
    chk({tag, ".Ovf"},   64'(Overflow),  64'(m_ovf));
    chk({tag, ".Udf"},   64'(Underflow), 64'(m_udf));
  endtask

  // Applies the FIFO rules to the model for the inputs of this cycle.
  task automatic model_step();
    bit empty, full, pop_ok, push_ok;
    if (!(ClockEnable && Tick)) return;
    if (Flush) begin
      mq.delete(); m_ovf = 0; m_udf = 0;
    end else if (pre) begin
      mq.delete(); mq.push_back('1);
    end else begin
      empty = (mq.size() == 0);
      full  = (mq.size() == DP);
      if (BYP && empty && Push && Pop) return;
      pop_ok  = Pop && !empty;
      push_ok = Push && (!full || pop_ok);
      if (Pop && empty)     m_udf = 1;
      if (Push && !push_ok) m_ovf = 1;
      if (pop_ok)  void'(mq.pop_front());
      if (push_ok) mq.push_back(D);
    end
  endtask

  // One clock: drive at the falling edge, check, then advance the model.
  task automatic cyc(input string tag, input bit ce, input bit tk,
                     input logic [NB-1:0] d, input bit pu, input bit po,
                     input bit fl, input bit pr, input bit c);
    @(negedge Clock);
    ClockEnable = ce; Tick = tk; D = d; Push = pu; Pop = po;
    Flush = fl; pre = pr; cs = c;
    #1;
    check_all(tag);
    model_step();
  endtask

  task automatic idle_inputs();
    ClockEnable = 1'b1; Tick = 1'b1; Push = 1'b0; Pop = 1'b0;
    Flush = 1'b0; pre = 1'b0; cs = 1'b0;
  endtask

  // Asynchronous reset asserted between edges; the queue must empty at once.
  task automatic do_reset();
    @(negedge Clock);
    idle_inputs();
    #2 Reset = 1'b0;
    #1;
    mq.delete(); m_ovf = 0; m_udf = 0;
    check_all("rst");
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  initial begin
    idle_inputs();
    #3;
    mq.delete(); m_ovf = 0; m_udf = 0;
    check_all("rst0");
    @(negedge Clock);
    Reset = 1'b1;

    // Reset state with no requests.
    cyc("idle", 1, 1, 32'h0, 0, 0, 0, 0, 0);
    // Fill, overflow, drain.
    cyc("p100", 1, 1, 32'h100, 1, 0, 0, 0, 0);
    cyc("p104", 1, 1, 32'h104, 1, 0, 0, 0, 0);
    cyc("p108", 1, 1, 32'h108, 1, 0, 0, 0, 0);
    cyc("p10c", 1, 1, 32'h10C, 1, 0, 0, 0, 0);
    cyc("p110", 1, 1, 32'h110, 1, 0, 0, 0, 0);
    cyc("full", 1, 1, 32'h0, 0, 0, 0, 0, 0);
    chk("dir.full_cnt", 64'(Count), 64'd4);
    chk("dir.full_q",   64'(Q),     64'h100);
    chk("dir.ovf",      64'(Overflow), 64'd1);
    repeat (4) cyc("pop", 1, 1, 32'h0, 0, 1, 0, 0, 0);
    cyc("drained", 1, 1, 32'h0, 0, 0, 0, 0, 0);
    chk("dir.empty_q", 64'(Q), 64'h0);
    // Refill, then simultaneous push+pop while full (wrap).
    for (int i = 0; i < 4; i++) cyc("refill", 1, 1, 32'h100 + 32'(4 * i), 1, 0, 0, 0, 0);
    cyc("pushpop", 1, 1, 32'h200, 1, 1, 0, 0, 0);
    cyc("pp_after", 1, 1, 32'h0, 0, 0, 0, 0, 0);
    chk("dir.pp_cnt", 64'(Count), 64'd4);
    chk("dir.pp_q",   64'(Q),     64'h104);
    repeat (3) cyc("pop", 1, 1, 32'h0, 0, 1, 0, 0, 0);
    cyc("last", 1, 1, 32'h0, 0, 0, 0, 0, 0);
    chk("dir.wrap_q", 64'(Q), 64'h200);
    cyc("pop", 1, 1, 32'h0, 0, 1, 0, 0, 0);
    cyc("flush", 1, 1, 32'h0, 0, 0, 1, 0, 0);
    // Tick low holds everything.
    repeat (5) cyc("notick", 1, 0, 32'h55, 1, 0, 0, 0, 0);
    repeat (2) cyc("noce", 0, 1, 32'h55, 1, 1, 1, 1, 0);
    // Flush beats pre; pre alone gives one all-ones entry.
    cyc("flpre", 1, 1, 32'h0, 0, 0, 1, 1, 0);
    cyc("pre", 1, 1, 32'h0, 0, 0, 0, 1, 0);
    cyc("pre_q", 1, 1, 32'h0, 0, 0, 0, 0, 0);
    chk("dir.pre_q", 64'(Q), 64'hFFFF_FFFF);
    // cs gating, underflow, flush clears flags.
    cyc("p2", 1, 1, 32'h2, 1, 0, 0, 0, 0);
    cyc("cs", 1, 1, 32'h0, 0, 0, 0, 0, 1);
    chk("dir.cs_q", 64'(Q), 64'h0);
    repeat (3) cyc("popu", 1, 1, 32'h0, 0, 1, 0, 0, 0);
    cyc("udf", 1, 1, 32'h0, 0, 0, 0, 0, 0);
    chk("dir.udf", 64'(Underflow), 64'd1);
    cyc("flush2", 1, 1, 32'h0, 0, 0, 1, 0, 0);
    // Push and pop together on an empty queue (bypass behaviour).
    cyc("byp", 1, 1, 32'h300, 1, 1, 0, 0, 0);
    cyc("byp_after", 1, 1, 32'h0, 0, 0, 0, 0, 0);
    chk("dir.byp_cnt", 64'(Count),     BYP ? 64'd0 : 64'd1);
    chk("dir.byp_udf", 64'(Underflow), BYP ? 64'd0 : 64'd1);
    cyc("flush3", 1, 1, 32'h0, 0, 0, 1, 0, 0);
    cyc("byp_nopop", 1, 1, 32'h304, 1, 0, 0, 0, 0);
    cyc("byp_np_after", 1, 1, 32'h0, 0, 0, 0, 0, 0);
    do_reset();

    // Randomised traffic with occasional asynchronous resets.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else
        cyc("rnd", $urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0,
            $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4,
            $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 6) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
